// File: rtl/gb_frame_scaler.sv
// gb_frame_scaler
//
// Sits behind the 858x525 HDMI timing generator. It follows the active-pixel
// position using the generator's strobes, reads the 160x144 GameBoy
// framebuffer (2-bit shades), and upscales the picture 3x into a 480x432
// window centred in the 720x480 active area. Pixels outside the window are
// black border. The pixel data leaves together with copies of
// hsync/vsync/de that are delayed by the same amount, so that the
// TMDS/output stage receives them aligned.
//
// Latency from an input sample to the matching output is RD_LAT+2 cycles,
// the same for every output:
//   stage 1        fb_addr / fb_rd_en registered
//   RD_LAT cycles  framebuffer read
//   output stage   data / hsync / vsync / de registered
//
// Ports
//   clk       in   pixel clock
//   rst       in   synchronous, active-high reset
//   hsync_in  in   timing generator hsync, active low
//   vsync_in  in   timing generator vsync, active low
//   de_in     in   timing generator active-video strobe
//   fb_rd_en  out  framebuffer read enable
//   fb_addr   out  framebuffer address, gb_y*GB_W + gb_x
//   fb_data   in   shade returned RD_LAT cycles after fb_addr/fb_rd_en
//   hsync     out  delayed hsync_in
//   vsync     out  delayed vsync_in
//   de        out  delayed de_in
//   data      out  {R[11:0], G[11:0], B[11:0]}

module gb_frame_scaler #(
   parameter int GB_W   = 160,
   parameter int GB_H   = 144,
   parameter int SCALE  = 3,
   parameter int H_OFF  = 120,
   parameter int V_OFF  = 24,
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        de_in,
   output logic        fb_rd_en,
   output logic [14:0] fb_addr,
   input  logic [1:0]  fb_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [35:0] data
);

   localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int GXW = $clog2(GB_W + 1);
   localparam int GYW = $clog2(GB_H + 1);

   localparam logic [9:0]     CNT_MAX   = 10'd1023;
   localparam logic [9:0]     X_LO      = 10'(H_OFF);
   localparam logic [9:0]     X_HI      = 10'(H_OFF + GB_W * SCALE);
   localparam logic [9:0]     Y_LO      = 10'(V_OFF);
   localparam logic [9:0]     Y_HI      = 10'(V_OFF + GB_H * SCALE);
   localparam logic [SW-1:0]  SUB_LAST  = SW'(SCALE - 1);
   localparam logic [14:0]    ROW_STEP  = 15'(GB_W);
   localparam logic [14:0]    ADDR_LAST = 15'(GB_W * GB_H - 1);
   localparam logic [GYW-1:0] GY_END    = GYW'(GB_H);

   // input edge detection and position tracking
   logic            de_q;
   logic            vs_q;
   logic            de_fall;
   logic            vs_fall;
   logic [9:0]      act_x;
   logic [9:0]      act_y;
   logic            locked;

   // framebuffer address generation
   logic [SW-1:0]   x_sub;
   logic [SW-1:0]   y_sub;
   logic [GXW-1:0]  gb_x;
   logic [GYW-1:0]  gb_y;
   logic [14:0]     row_base;

   logic            h_in;
   logic            v_in;
   logic            win;
   logic [14:0]     addr_nxt;
   logic            rd_nxt;

   // Delay lines. Index 0 holds stage 1 and index RD_LAT lines up with fb_data.
   logic [RD_LAT:0] hs_dl;
   logic [RD_LAT:0] vs_dl;
   logic [RD_LAT:0] de_dl;
   logic [RD_LAT:0] win_dl;

   logic [11:0]     lvl;

   always_comb begin
      de_fall  = de_q & ~de_in;
      vs_fall  = vs_q & ~vsync_in;
      h_in     = (act_x >= X_LO) && (act_x < X_HI);
      v_in     = (act_y >= Y_LO) && (act_y < Y_HI);
      win      = locked & de_in & h_in & v_in;
      addr_nxt = row_base + 15'(gb_x);
      // The window bounds already keep the address in range. This guard makes
      // sure no read can leave the framebuffer even if the strobes misbehave.
      rd_nxt   = win && (gb_y < GY_END) && (addr_nxt <= ADDR_LAST);
   end

   // act_x counts the de cycles of the current line. act_y counts completed
   // lines since the last vsync fall. Both saturate so that junk timing can
   // never wrap them back into the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_q   <= 1'b0;
         vs_q   <= 1'b1;
         act_x  <= '0;
         act_y  <= '0;
         locked <= 1'b0;
      end else begin
         de_q <= de_in;
         vs_q <= vsync_in;

         if (!de_in)
            act_x <= '0;
         else if (act_x != CNT_MAX)
            act_x <= act_x + 10'd1;

         if (vs_fall)
            act_y <= '0;
         else if (de_fall && (act_y != CNT_MAX))
            act_y <= act_y + 10'd1;

         if (vs_fall)
            locked <= 1'b1;
      end
   end

   // Address walk with no multiplier: x_sub/y_sub repeat every GB pixel
   // SCALE times, and row_base steps by GB_W once per SCALE lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_sub    <= '0;
         gb_x     <= '0;
         y_sub    <= '0;
         gb_y     <= '0;
         row_base <= '0;
      end else begin
         if (vs_fall || de_fall) begin
            x_sub <= '0;
            gb_x  <= '0;
         end else if (win) begin
            if (x_sub == SUB_LAST) begin
               x_sub <= '0;
               gb_x  <= gb_x + GXW'(1);
            end else begin
               x_sub <= x_sub + SW'(1);
            end
         end

         if (vs_fall) begin
            y_sub    <= '0;
            gb_y     <= '0;
            row_base <= '0;
         end else if (de_fall && v_in) begin
            if (y_sub == SUB_LAST) begin
               y_sub    <= '0;
               gb_y     <= gb_y + GYW'(1);
               row_base <= row_base + ROW_STEP;
            end else begin
               y_sub <= y_sub + SW'(1);
            end
         end
      end
   end

   // stage 1: framebuffer request
   always_ff @(posedge clk) begin
      if (rst) begin
         fb_rd_en <= 1'b0;
         fb_addr  <= '0;
      end else begin
         fb_rd_en <= rd_nxt;
         fb_addr  <= rd_nxt ? addr_nxt : 15'd0;
      end
   end

   // The sync and de delay lines reset to idle (syncs high, de low), so a
   // reset also flushes every pixel that is still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_dl  <= '1;
         vs_dl  <= '1;
         de_dl  <= '0;
         win_dl <= '0;
      end else begin
         hs_dl  <= {hs_dl[RD_LAT-1:0], hsync_in};
         vs_dl  <= {vs_dl[RD_LAT-1:0], vsync_in};
         de_dl  <= {de_dl[RD_LAT-1:0], de_in};
         win_dl <= {win_dl[RD_LAT-1:0], rd_nxt};
      end
   end

   // grey palette: shade 0 is the lightest
   always_comb begin
      lvl = 12'h000;
      case (fb_data)
         2'd0:    lvl = 12'hFFF;
         2'd1:    lvl = 12'hAAA;
         2'd2:    lvl = 12'h555;
         default: lvl = 12'h000;
      endcase
   end

   // output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         de    <= 1'b0;
         data  <= '0;
      end else begin
         hsync <= hs_dl[RD_LAT];
         vsync <= vs_dl[RD_LAT];
         de    <= de_dl[RD_LAT];
         if (de_dl[RD_LAT] && win_dl[RD_LAT])
            data <= {lvl, lvl, lvl};
         else
            data <= '0;
      end
   end

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Bench for gb_frame_scaler. It runs three instances at the same time, with
// RD_LAT = 1, 2 and 4, each one with its own framebuffer model. The timing
// generator below produces shortened frames: only a few lines are full
// 720-pixel lines, and the other lines carry a 4-pixel de burst so that act_y
// still advances. The expectation model works from the generator's own
// (x, y) pixel coordinates and the frame-lock rule.
module tb_gb_frame_scaler;

   localparam int N = 65536;

   logic clk = 1'b0;
   logic rst, hsync_in, vsync_in, de_in;

   logic        en1, en2, en4;
   logic [14:0] a1, a2, a4;
   logic [1:0]  d1, d2, d4;
   logic        hs1, hs2, hs4, vs1, vs2, vs4, de1, de2, de4;
   logic [35:0] o1, o2, o4;

   always #5 clk = ~clk;

   gb_frame_scaler #(.RD_LAT(1)) u_d1 (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
      .fb_rd_en(en1), .fb_addr(a1), .fb_data(d1),
      .hsync(hs1), .vsync(vs1), .de(de1), .data(o1));
   gb_frame_scaler #(.RD_LAT(2)) u_d2 (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
      .fb_rd_en(en2), .fb_addr(a2), .fb_data(d2),
      .hsync(hs2), .vsync(vs2), .de(de2), .data(o2));
   gb_frame_scaler #(.RD_LAT(4)) u_d4 (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
      .fb_rd_en(en4), .fb_addr(a4), .fb_data(d4),
      .hsync(hs4), .vsync(vs4), .de(de4), .data(o4));

   // framebuffer contents: addresses 0..3 hold shades 0,1,2,3
   function automatic int shade_of(input int a);
      return (a + (a >> 4)) % 4;
   endfunction

   function automatic logic [35:0] pal(input int s);
      case (s)
         0:       return 36'hFFFFFFFFF;
         1:       return 36'hAAAAAAAAA;
         2:       return 36'h555555555;
         default: return 36'h000000000;
      endcase
   endfunction

   // framebuffer models with fixed read latency
   logic [1:0] m1, m2a, m2b, m4a, m4b, m4c, m4d;
   always @(posedge clk) begin
      m1  <= 2'(shade_of(int'(a1)));
      m2a <= 2'(shade_of(int'(a2)));
      m2b <= m2a;
      m4a <= 2'(shade_of(int'(a4)));
      m4b <= m4a;
      m4c <= m4b;
      m4d <= m4c;
   end
   assign d1 = m1;
   assign d2 = m2b;
   assign d4 = m4d;

   // input history, one entry per driven cycle
   bit h_hs[N], h_vs[N], h_de[N], h_rst[N], h_win[N];
   int h_addr[N], h_ax[N], h_ay[N], h_fr[N];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int n_print = 0;
   bit done = 0;
   int rst_left = 0;
   int frm = 0;
   bit locked_m = 0;
   bit prev_vs = 1;

   task automatic step(input bit hs, input bit vs, input bit dv, input int ax, input int ay,
                       input bit r_req);
      bit r;
      bit w;
      int ad;
      @(negedge clk);
      r = r_req || (rst_left > 0);
      if (rst_left > 0) rst_left--;
      rst = r; hsync_in = hs; vsync_in = vs; de_in = dv;
      w = 0; ad = 0;
      if (r) begin
         locked_m = 0;
         prev_vs = 1;
      end else begin
         w = locked_m && dv && ax >= 120 && ax < 600 && ay >= 24 && ay < 456;
         if (w) ad = ((ay - 24) / 3) * 160 + (ax - 120) / 3;
         if (prev_vs && !vs) locked_m = 1;
         prev_vs = vs;
      end
      if (cyc >= N) begin
         $display("FAIL hist_overflow cyc=%0d limit=%0d", cyc, N);
         $fatal(1);
      end
      h_hs[cyc] = hs; h_vs[cyc] = vs; h_de[cyc] = dv; h_rst[cyc] = r;
      h_win[cyc] = w; h_addr[cyc] = ad; h_ax[cyc] = ax; h_ay[cyc] = ay; h_fr[cyc] = frm;
      cyc++;
   endtask

   function automatic bit is_full(input int y);
      return y == 0 || (y >= 24 && y <= 28) || y == 100 || y == 454 || y == 455 ||
             y == 456 || y == 479;
   endfunction

   task automatic do_line(input int ay, input int nde, input bit vs, input int rst_line);
      for (int x = 0; x < nde; x++) step(1'b1, vs, 1'b1, x, ay, (ay == rst_line) && x < 2);
      for (int b = 0; b < 10; b++) step(!(b >= 3 && b < 6), vs, 1'b0, 0, ay, 1'b0);
   endtask

   task automatic do_frame(input int first, input int last, input int rst_line, input bit vblank);
      for (int y = first; y <= last; y++) do_line(y, is_full(y) ? 720 : 4, 1'b1, rst_line);
      if (vblank)
         for (int y = 480; y < 490; y++)
            do_line(y, (y == 481) ? 1 : 0, !(y >= 483 && y <= 485), -1);
   endtask

   task automatic tally(input bit ok, input string what, input string nm, input int idx,
                        input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s[%s] idx=%0d got=%h expected=%h", what, nm, idx, got, exp);
         end
      end
   endtask

   task automatic check_inst(input string nm, input int lat, input logic en, input logic [14:0] addr,
                             input logic ohs, input logic ovs, input logic ode,
                             input logic [35:0] odat);
      int j1, j;
      bit fl;
      logic [38:0] got, exp;
      j1 = cyc - 1;
      if (j1 >= 0) begin
         tally(en === h_win[j1], "rd_en", nm, j1, 64'(en), 64'(h_win[j1]));
         if (h_win[j1])
            tally(addr === 15'(h_addr[j1]), "addr", nm, j1, 64'(addr), 64'(h_addr[j1]));
         if (h_de[j1]) begin
            if (h_fr[j1] == 1 && h_ay[j1] == 24 && h_ax[j1] == 119)
               tally(en === 1'b0, "lit_rd_119", nm, j1, 64'(en), 64'd0);
            if (h_fr[j1] == 1 && h_ay[j1] == 24 && h_ax[j1] == 120)
               tally(en === 1'b1 && addr === 15'd0, "lit_first", nm, j1, {en, addr}, {1'b1, 15'd0});
            if (h_fr[j1] == 1 && h_ay[j1] == 24 && h_ax[j1] == 599)
               tally(addr === 15'd159, "lit_l24_end", nm, j1, 64'(addr), 64'd159);
            if (h_fr[j1] == 1 && h_ay[j1] == 24 && h_ax[j1] == 600)
               tally(en === 1'b0, "lit_rd_600", nm, j1, 64'(en), 64'd0);
            if (h_fr[j1] == 1 && h_ay[j1] == 26 && h_ax[j1] == 599)
               tally(addr === 15'd159, "lit_l26_end", nm, j1, 64'(addr), 64'd159);
            if (h_fr[j1] == 1 && h_ay[j1] == 27 && h_ax[j1] == 120)
               tally(addr === 15'd160, "lit_l27", nm, j1, 64'(addr), 64'd160);
            if (h_fr[j1] == 1 && h_ay[j1] == 455 && h_ax[j1] == 120)
               tally(addr === 15'd22880, "lit_l455_start", nm, j1, 64'(addr), 64'd22880);
            if (h_fr[j1] == 1 && h_ay[j1] == 455 && h_ax[j1] == 599)
               tally(addr === 15'd23039, "lit_l455_end", nm, j1, 64'(addr), 64'd23039);
            if (h_fr[j1] == 1 && h_ay[j1] == 456 && h_ax[j1] == 300)
               tally(en === 1'b0, "lit_l456", nm, j1, 64'(en), 64'd0);
            if (h_fr[j1] == 2 && h_ay[j1] == 454 && h_ax[j1] == 300)
               tally(en === 1'b0, "lit_after_rst", nm, j1, 64'(en), 64'd0);
            if (h_fr[j1] == 3 && h_ay[j1] == 24 && h_ax[j1] == 120)
               tally(en === 1'b1 && addr === 15'd0, "lit_relock", nm, j1, {en, addr}, {1'b1, 15'd0});
         end
      end
      j = cyc - lat;
      if (j >= 0) begin
         fl = 0;
         for (int i = j; i < j + lat; i++) if (h_rst[i]) fl = 1;
         if (fl)
            exp = {1'b1, 1'b1, 1'b0, 36'h0};
         else
            exp = {h_hs[j], h_vs[j], h_de[j],
                   (h_de[j] && h_win[j]) ? pal(shade_of(h_addr[j])) : 36'h0};
         got = {ohs, ovs, ode, odat};
         tally(got === exp, "out", nm, j, 64'(got), 64'(exp));
         if (h_de[j] && h_fr[j] == 1 && h_ay[j] == 24) begin
            if (h_ax[j] == 120) tally(odat === 36'hFFFFFFFFF, "lit_pal0", nm, j, 64'(odat), 64'hFFFFFFFFF);
            if (h_ax[j] == 123) tally(odat === 36'hAAAAAAAAA, "lit_pal1", nm, j, 64'(odat), 64'hAAAAAAAAA);
            if (h_ax[j] == 126) tally(odat === 36'h555555555, "lit_pal2", nm, j, 64'(odat), 64'h555555555);
            if (h_ax[j] == 129) tally(odat === 36'h0, "lit_pal3", nm, j, 64'(odat), 64'h0);
            if (h_ax[j] == 600) tally(odat === 36'h0, "lit_border_r", nm, j, 64'(odat), 64'h0);
         end
         if (h_de[j] && h_fr[j] == 1 && h_ay[j] == 456 && h_ax[j] == 300)
            tally({ode, odat} === {1'b1, 36'h0}, "lit_border_b", nm, j, 64'({ode, odat}),
                  64'({1'b1, 36'h0}));
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (!done) begin
         check_inst("lat1", 3, en1, a1, hs1, vs1, de1, o1);
         check_inst("lat2", 4, en2, a2, hs2, vs2, de2, o2);
         check_inst("lat4", 6, en4, a4, hs4, vs4, de4, o4);
      end
   end

   initial begin
      rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
      rst_left = 5;
      frm = 0; do_frame(300, 479, -1, 1'b1);
      frm = 1; do_frame(0, 479, -1, 1'b1);
      frm = 2; do_frame(0, 479, 200, 1'b1);
      frm = 3; do_frame(0, 30, -1, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 0, 999, 1'b0);
      @(negedge clk);
      done = 1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
